sbus_arbiter: RTL

- Parametrised N-to-1 arbiter that merges several sbus-style master channels (ibus, dbus, future uncached and DMA ports) onto one downstream bus port.
- Sits between the mmu outputs and the external bus bridge.
- Adds selectable fixed-priority or round-robin arbitration, a registered response path and a per-transaction slave timeout that returns a bus error.

---
 rtl/sbus_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sbus_arbiter.sv
// N-to-1 sbus arbiter: fixed-priority or round-robin grant, registered response path
// and a per-transaction slave timeout that completes the master with a bus error.
module sbus_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RR_MODE   = 1,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned IDX_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int unsigned BE_W     = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_we,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*BE_W-1:0]     m_be,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [BE_W-1:0]               s_be,
  input  logic                          s_ack,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [IDX_W-1:0]              grant_id
);

  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CNT_MAX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   s_req_q, s_req_d;
  logic                   s_we_q, s_we_d;
  logic [ADDR_W-1:0]      s_addr_q, s_addr_d;
  logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
  logic [BE_W-1:0]        s_be_q, s_be_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [N_MASTERS-1:0]   ack_q, ack_d;
  logic [N_MASTERS-1:0]   err_q, err_d;

  logic                   win_valid;
  logic [IDX_W-1:0]       win_idx;
  int unsigned            sel;

  // Winner selection; only consumed in StIdle.
  always_comb begin
    int unsigned cand;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    if (RR_MODE != 0) begin
      for (int unsigned k = 1; k <= N_MASTERS; k++) begin
        cand = (32'(rr_ptr_q) + k) % N_MASTERS;
        if (!win_valid && m_req[cand]) begin
          win_valid = 1'b1;
          win_idx   = IDX_W'(cand);
        end
      end
    end else begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        if (!win_valid && m_req[i]) begin
          win_valid = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign sel = 32'(win_idx);

  always_comb begin
    state_d   = state_q;
    s_req_d   = s_req_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_be_d    = s_be_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    ack_d     = '0;
    err_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          s_req_d   = 1'b1;
          s_we_d    = m_we[sel];
          s_addr_d  = m_addr[sel*ADDR_W +: ADDR_W];
          s_wdata_d = m_wdata[sel*DATA_W +: DATA_W];
          s_be_d    = m_be[sel*BE_W +: BE_W];
          grant_d   = win_idx;
          if (RR_MODE != 0) rr_ptr_d = win_idx;
          cnt_d     = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        // A slave ack in the final timeout cycle takes precedence over the error.
        if (s_ack) begin
          rdata_d        = s_rdata;
          s_req_d        = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = StResp;
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(CNT_MAX)) begin
          rdata_d        = '0;
          s_req_d        = 1'b0;
          ack_d[grant_q] = 1'b1;
          err_d[grant_q] = 1'b1;
          state_d        = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      s_req_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_be_q    <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= IDX_W'(N_MASTERS - 1);
      cnt_q     <= '0;
      rdata_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_be_q    <= s_be_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign s_req    = s_req_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_be     = s_be_q;
  assign grant_id = grant_q;
  assign m_rdata  = rdata_q;
  assign m_ack    = ack_q;
  assign m_err    = err_q;

endmodule
